// File: rtl/spi_txn_arbiter.sv
// Round-robin arbiter sharing one SPI master engine among NUM_REQ requesters,
// with a transfer watchdog and an ss-high guard gap between transfers.
//
// state | meaning
// IDLE  | no transfer; scan requests starting after the last grantee
// WAIT  | engine enabled, waiting for spi_done or the watchdog
// GUARD | ack issued, enforcing the guard gap and waiting for the engine to re-arm
module spi_txn_arbiter #(
    parameter int NUM_REQ     = 4,
    parameter int TIMEOUT_CYC = 4096,
    parameter int GAP_CYC     = 100
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NUM_REQ-1:0]    req,
    input  logic [16*NUM_REQ-1:0] req_word,
    output logic [NUM_REQ-1:0]    req_ack,
    output logic [7:0]            rsp_byte,
    output logic                  rsp_err,
    output logic                  busy,
    output logic [1:0]            owner,
    output logic                  spi_enable,
    output logic [15:0]           spi_word,
    input  logic                  spi_done,
    input  logic [7:0]            spi_rx
);

    typedef enum logic [1:0] {IDLE, WAIT, GUARD} state_t;

    localparam logic [12:0] TIMER_TO = 13'(TIMEOUT_CYC - 1);
    localparam logic [12:0] GAP_SAT  = 13'(GAP_CYC);
    localparam logic [12:0] GAP_LAST = 13'(GAP_CYC - 1);

    state_t               state, state_d;
    logic [1:0]           last, last_d;
    logic [12:0]          timer, timer_d;
    logic [NUM_REQ-1:0]   ack_d;
    logic [7:0]           byte_d;
    logic                 err_d, busy_d, en_d;
    logic [1:0]           owner_d;
    logic [15:0]          word_d;

    logic                 found;
    logic [1:0]           gnt;
    logic [15:0]          gnt_word;

    // First requester after the previous grantee wins, wrapping modulo NUM_REQ.
    always_comb begin
        found    = 1'b0;
        gnt      = '0;
        gnt_word = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (!found && req[i] && (i == (int'(last) + k) % NUM_REQ)) begin
                    found = 1'b1;
                    gnt   = 2'(i);
                end
            end
        end
        for (int i = 0; i < NUM_REQ; i++) begin
            if (gnt == 2'(i)) gnt_word = req_word[16*i +: 16];
        end
    end

    always_comb begin
        state_d = state;
        last_d  = last;
        timer_d = timer;
        ack_d   = '0;
        byte_d  = rsp_byte;
        err_d   = rsp_err;
        busy_d  = busy;
        owner_d = owner;
        en_d    = spi_enable;
        word_d  = spi_word;
        case (state)
            IDLE: begin
                if (found) begin
                    state_d = WAIT;
                    owner_d = gnt;
                    last_d  = gnt;
                    word_d  = gnt_word;
                    en_d    = 1'b1;
                    busy_d  = 1'b1;
                    timer_d = '0;
                end
            end
            WAIT: begin
                timer_d = timer + 13'd1;
                if (spi_done || timer == TIMER_TO) begin
                    for (int i = 0; i < NUM_REQ; i++) begin
                        if (owner == 2'(i)) ack_d[i] = 1'b1;
                    end
                    byte_d  = spi_done ? spi_rx : 8'h00;
                    err_d   = !spi_done;
                    en_d    = 1'b0;
                    timer_d = '0;
                    state_d = GUARD;
                end
            end
            GUARD: begin
                if (timer < GAP_SAT) timer_d = timer + 13'd1;
                // The engine must have dropped done before another grant is allowed.
                if (timer >= GAP_LAST && !spi_done) begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            last       <= 2'(NUM_REQ - 1);
            timer      <= '0;
            req_ack    <= '0;
            rsp_byte   <= '0;
            rsp_err    <= 1'b0;
            busy       <= 1'b0;
            owner      <= '0;
            spi_enable <= 1'b0;
            spi_word   <= '0;
        end else begin
            state      <= state_d;
            last       <= last_d;
            timer      <= timer_d;
            req_ack    <= ack_d;
            rsp_byte   <= byte_d;
            rsp_err    <= err_d;
            busy       <= busy_d;
            owner      <= owner_d;
            spi_enable <= en_d;
            spi_word   <= word_d;
        end
    end

endmodule
